yuv422_stream_sequencer: RTL and testbench
==========================================

// Module: yuv422_stream_sequencer
// PURPOSE
//  Frame/line sequencer for the YUV422->YUV444 converter. Watches the camera
//  stream (iFVAL/iDVAL) and drives the converter enable and chroma phase, so
//  every line starts on a Cb sample. Emits pixel/line coordinates and sync
//  pulses aligned to the converter's 1-cycle-late Y/Cb/Cr output. Also
//  detects malformed lines and frames. Sits between the camera capture and
//  the converter, feeding the downstream tracking pipeline.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line; must be even
//  V_ACTIVE  480  active lines per frame
//  XW        11   width of oX; must satisfy 2**XW > H_ACTIVE
//  YW        10   width of oY; must satisfy 2**YW > V_ACTIVE
// PORTS
//  iCLK       in   1   clock; all logic on rising edge
//  iRST       in   1   synchronous, active-high reset
//  iFVAL      in   1   frame valid from capture
//  iDVAL      in   1   pixel valid; one 16-bit 422 word per cycle when high
//  oCONV_EN   out  1   converter sample enable (combinational)
//  oPHASE_CR  out  1   0 = this word carries Cb, 1 = Cr (combinational)
//  oDVAL      out  1   converter output valid (registered)
//  oX         out  XW  pixel index of oDVAL word
//  oY         out  YW  line index of oDVAL word
//  oSOF       out  1   pulse with first pixel of frame (x=0, y=0)
//  oEOL       out  1   pulse with last pixel of each line
//  oEOF       out  1   pulse with last pixel of frame
//  oERR       out  1   one-cycle error pulse
//  oERR_CNT   out  8   saturating error count; cleared only by reset
// BEHAVIOUR
//  Reset: state=S_IDLE, counters=0, phase=0.
//   All registered outputs are 0, including oERR_CNT.
//  States:
//   S_IDLE   waits for a rising edge of iFVAL (registered iFVAL was 0, now 1),
//            then -> S_ACTIVE with x=0, y=0, phase=0. Data arriving on the
//            rising-edge cycle is accepted.
//   S_ACTIVE accepts a word on each cycle with iDVAL=1. Each accepted word
//            toggles phase and increments x. When x reaches H_ACTIVE-1:
//            x<=0, phase<=0, y++. On the last pixel of line V_ACTIVE-1
//            -> S_DRAIN.
//   S_DRAIN  ignores data; when iFVAL=0 -> S_IDLE.
//  oCONV_EN = iDVAL & (state==S_ACTIVE); oPHASE_CR = phase.
//   The converter samples the word in the same cycle.
//  Latency: oDVAL/oX/oY/oSOF/oEOL/oEOF are asserted exactly 1 cycle after
//   the accepted word, aligned with the converter output registers.
//  Errors (oERR high for 1 cycle, oERR_CNT++ unless already 255):
//   - iFVAL falls in S_ACTIVE before the frame completes: -> S_IDLE, counters=0.
//     A partial line is dropped and no oEOL/oEOF is issued for it.
//   - iDVAL=1 in S_DRAIN (frame too long): data is discarded; one error per
//     offending cycle.
//  Simultaneous events: iFVAL falls on the cycle of the final pixel -> that
//   pixel is accepted, oEOF is issued, -> S_IDLE, and no error is raised.
//  A gap in iDVAL mid-line holds x and phase (no timeout).
//  Reset mid-frame: back to S_IDLE. The frame restarts only on the next
//   iFVAL rising edge, even if iFVAL is still high.
// STRUCTURE
//  Shared package yuv_pipe_pkg:
//   - state encodings S_IDLE=2'd0, S_ACTIVE=2'd1, S_DRAIN=2'd2
//   - default H_ACTIVE/V_ACTIVE constants
//  Sub-module yuv_err_counter: 8-bit saturating counter with inc input.
//  Everything else (FSM, x/y counters, output stage) is flat in this module.
// TESTING
//  1. H=8,V=2, clean frame with iDVAL continuous:
//     -> oPHASE_CR sequence 0,1,0,1...; oSOF at x0y0; oEOL at x7; oEOF at x7y1;
//        16 oDVAL pulses.
//  2. iDVAL gaps of 3 cycles every other word:
//     -> x/phase held across gaps; oDVAL count still 16; no oERR.
//  3. iFVAL drops after 5 pixels of line 1:
//     -> oERR pulse, oERR_CNT=1, no oEOF; the next frame starts at x0y0 with
//        phase 0.
//  4. 4 extra iDVAL words after frame end, iFVAL still high:
//     -> 4 oERR pulses, oERR_CNT=4, oCONV_EN stays 0.
//  5. iRST asserted mid-line 0 with iFVAL held high:
//     -> all outputs 0, no activity until iFVAL toggles 0->1.
//  6. 300 bad frames:
//     -> oERR_CNT saturates at 255. iFVAL falling on the final pixel
//        -> oEOF, no error.

Source files
------------

// File: rtl/yuv_pipe_pkg.sv
// Shared types and default geometry for the YUV422 capture/convert pipeline.
package yuv_pipe_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } seq_state_e;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned XW_DEF       = 11;
  localparam int unsigned YW_DEF       = 10;
  localparam int unsigned ERR_CNT_W    = 8;

endpackage

// File: rtl/yuv_err_counter.sv
// Saturating event counter; holds at all-ones and clears only on reset.
module yuv_err_counter
  import yuv_pipe_pkg::*;
#(
  parameter int unsigned W = ERR_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/yuv422_stream_sequencer.sv
// Frame/line sequencer for the YUV422->YUV444 converter: drives converter
// enable and chroma phase, and emits coordinates/syncs aligned to its output.
module yuv422_stream_sequencer
  import yuv_pipe_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned XW       = XW_DEF,
  parameter int unsigned YW       = YW_DEF
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iFVAL,
  input  logic                 iDVAL,
  output logic                 oCONV_EN,
  output logic                 oPHASE_CR,
  output logic                 oDVAL,
  output logic [XW-1:0]        oX,
  output logic [YW-1:0]        oY,
  output logic                 oSOF,
  output logic                 oEOL,
  output logic                 oEOF,
  output logic                 oERR,
  output logic [ERR_CNT_W-1:0] oERR_CNT
);

  seq_state_e state_q, state_d;

  logic          fval_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          phase_q, phase_d;

  logic          fval_rise_c;
  logic          line_end_c;
  logic          frame_end_c;
  logic          accept_c;
  logic          err_c;
  logic          abort_c;

  logic          dval_q;
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;
  logic          sof_q;
  logic          eol_q;
  logic          eof_q;
  logic          err_q;

  assign fval_rise_c = iFVAL & ~fval_q;
  assign line_end_c  = (x_q == XW'(H_ACTIVE - 1));
  assign frame_end_c = line_end_c && (y_q == YW'(V_ACTIVE - 1));

  // fval_q resets high so a frame already in flight is not mistaken for a new one.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      fval_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fval_rise_c) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (accept_c && frame_end_c) begin
          state_d = iFVAL ? S_DRAIN : S_IDLE;
        end else if (!iFVAL) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!iFVAL) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Final pixel may still be taken on the cycle iFVAL drops; anything else is a short frame.
  always_comb begin
    accept_c = 1'b0;
    err_c    = 1'b0;
    abort_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        accept_c = iDVAL & fval_rise_c;
      end
      S_ACTIVE: begin
        accept_c = iDVAL & (iFVAL | frame_end_c);
        abort_c  = ~iFVAL & ~accept_c;
        err_c    = abort_c;
      end
      S_DRAIN: begin
        err_c = iDVAL;
      end
      default: begin
        accept_c = 1'b0;
      end
    endcase
  end

  assign oCONV_EN  = accept_c;
  assign oPHASE_CR = phase_q;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    phase_d = phase_q;
    if (abort_c) begin
      x_d     = '0;
      y_d     = '0;
      phase_d = 1'b0;
    end else if (accept_c) begin
      if (line_end_c) begin
        x_d     = '0;
        phase_d = 1'b0;
        y_d     = frame_end_c ? '0 : y_q + YW'(1);
      end else begin
        x_d     = x_q + XW'(1);
        phase_d = ~phase_q;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_q     <= '0;
      y_q     <= '0;
      phase_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      phase_q <= phase_d;
    end
  end

  // Output stage lines up with the converter's registered Y/Cb/Cr.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dval_q <= 1'b0;
      ox_q   <= '0;
      oy_q   <= '0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      eof_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dval_q <= accept_c;
      sof_q  <= accept_c && (x_q == '0) && (y_q == '0);
      eol_q  <= accept_c && line_end_c;
      eof_q  <= accept_c && frame_end_c;
      err_q  <= err_c;
      if (accept_c) begin
        ox_q <= x_q;
        oy_q <= y_q;
      end
    end
  end

  yuv_err_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk_i(iCLK),
    .rst_i(iRST),
    .inc_i(err_c),
    .cnt_o(oERR_CNT)
  );

  assign oDVAL = dval_q;
  assign oX    = ox_q;
  assign oY    = oy_q;
  assign oSOF  = sof_q;
  assign oEOL  = eol_q;
  assign oEOF  = eof_q;
  assign oERR  = err_q;

endmodule

// File: tb/tb_yuv422_stream_sequencer.sv
// Directed bench for yuv422_stream_sequencer with an 8x2 frame geometry.
module tb_yuv422_stream_sequencer;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iFVAL;
  logic       iDVAL;
  logic       oCONV_EN;
  logic       oPHASE_CR;
  logic       oDVAL;
  logic [3:0] oX;
  logic [1:0] oY;
  logic       oSOF;
  logic       oEOL;
  logic       oEOF;
  logic       oERR;
  logic [7:0] oERR_CNT;

  int n_pass  = 0;
  int n_total = 0;
  int dval_cnt, err_cnt, eof_cnt, sof_cnt;
  logic conv_en_s, phase_s;

  yuv422_stream_sequencer #(
    .H_ACTIVE(8),
    .V_ACTIVE(2),
    .XW(4),
    .YW(2)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iFVAL(iFVAL),
    .iDVAL(iDVAL),
    .oCONV_EN(oCONV_EN),
    .oPHASE_CR(oPHASE_CR),
    .oDVAL(oDVAL),
    .oX(oX),
    .oY(oY),
    .oSOF(oSOF),
    .oEOL(oEOL),
    .oEOF(oEOF),
    .oERR(oERR),
    .oERR_CNT(oERR_CNT)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clr_acc();
    dval_cnt = 0;
    err_cnt  = 0;
    eof_cnt  = 0;
    sof_cnt  = 0;
  endtask

  // Drive one cycle; sample comb outputs before the edge, registered ones after it.
  task automatic cyc(input logic f, input logic d);
    iFVAL = f;
    iDVAL = d;
    #1;
    conv_en_s = oCONV_EN;
    phase_s   = oPHASE_CR;
    @(posedge iCLK);
    #1;
    if (oDVAL) dval_cnt++;
    if (oERR)  err_cnt++;
    if (oEOF)  eof_cnt++;
    if (oSOF)  sof_cnt++;
  endtask

  initial begin
    iRST  = 1'b1;
    iFVAL = 1'b1;
    iDVAL = 1'b1;
    clr_acc();
    @(posedge iCLK);
    #1;
    cyc(1'b1, 1'b1);
    chk("rst_dval", 32'(oDVAL), 32'd0);
    chk("rst_errcnt", 32'(oERR_CNT), 32'd0);
    chk("rst_x", 32'(oX), 32'd0);
    chk("rst_sof", 32'(oSOF), 32'd0);
    iRST = 1'b0;
    cyc(1'b0, 1'b0);
    chk("idle_conv_en", 32'(conv_en_s), 32'd0);

    // Clean continuous frame
    clr_acc();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1);
      chk("t1_conv_en", 32'(conv_en_s), 32'd1);
      chk("t1_phase", 32'(phase_s), 32'(i % 2));
      chk("t1_dval", 32'(oDVAL), 32'd1);
      chk("t1_x", 32'(oX), 32'(i % 8));
      chk("t1_y", 32'(oY), 32'(i / 8));
      chk("t1_sof", 32'(oSOF), 32'(i == 0));
      chk("t1_eol", 32'(oEOL), 32'(i % 8 == 7));
      chk("t1_eof", 32'(oEOF), 32'(i == 15));
    end
    cyc(1'b1, 1'b0);
    chk("t1_drain_dval", 32'(oDVAL), 32'd0);
    cyc(1'b0, 1'b0);
    chk("t1_dval_cnt", 32'(dval_cnt), 32'd16);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);

    // Gaps of 3 cycles after every even word
    clr_acc();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1);
      chk("t2_phase", 32'(phase_s), 32'(i % 2));
      chk("t2_x", 32'(oX), 32'(i % 8));
      chk("t2_y", 32'(oY), 32'(i / 8));
      if (i % 2 == 0) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b1, 1'b0);
          chk("t2_gap_phase", 32'(phase_s), 32'd1);
          chk("t2_gap_dval", 32'(oDVAL), 32'd0);
          chk("t2_gap_x", 32'(oX), 32'(i % 8));
        end
      end
    end
    cyc(1'b0, 1'b0);
    chk("t2_dval_cnt", 32'(dval_cnt), 32'd16);
    chk("t2_eof_cnt", 32'(eof_cnt), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);

    // iFVAL drops after 5 pixels of line 1
    clr_acc();
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("t3_err", 32'(oERR), 32'd1);
    chk("t3_errcnt", 32'(oERR_CNT), 32'd1);
    chk("t3_eof_cnt", 32'(eof_cnt), 32'd0);
    cyc(1'b0, 1'b0);
    chk("t3_err_pulse", 32'(oERR), 32'd0);
    cyc(1'b1, 1'b1);
    chk("t3_restart_phase", 32'(phase_s), 32'd0);
    chk("t3_restart_sof", 32'(oSOF), 32'd1);
    chk("t3_restart_x", 32'(oX), 32'd0);
    chk("t3_restart_y", 32'(oY), 32'd0);
    for (int i = 1; i < 16; i++) cyc(1'b1, 1'b1);
    chk("t3_frame_eof", 32'(oEOF), 32'd1);

    // Four surplus words while draining
    clr_acc();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1);
      chk("t4_conv_en", 32'(conv_en_s), 32'd0);
      chk("t4_err", 32'(oERR), 32'd1);
      chk("t4_dval", 32'(oDVAL), 32'd0);
    end
    chk("t4_err_cnt", 32'(err_cnt), 32'd4);
    chk("t4_errcnt_total", 32'(oERR_CNT), 32'd5);
    cyc(1'b0, 1'b0);
    chk("t4_idle_err", 32'(oERR), 32'd0);

    // Reset mid-line 0 with iFVAL held high
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    iRST = 1'b1;
    cyc(1'b1, 1'b1);
    chk("t5_dval", 32'(oDVAL), 32'd0);
    chk("t5_errcnt", 32'(oERR_CNT), 32'd0);
    chk("t5_x", 32'(oX), 32'd0);
    chk("t5_y", 32'(oY), 32'd0);
    chk("t5_err", 32'(oERR), 32'd0);
    iRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      chk("t5_hold_conv_en", 32'(conv_en_s), 32'd0);
      chk("t5_hold_dval", 32'(oDVAL), 32'd0);
    end
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    chk("t5_restart_conv_en", 32'(conv_en_s), 32'd1);
    chk("t5_restart_sof", 32'(oSOF), 32'd1);
    cyc(1'b0, 1'b0);
    chk("t5_abort_errcnt", 32'(oERR_CNT), 32'd1);

    // 300 bad frames saturate the error counter
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
      chk("t6_err", 32'(oERR), 32'd1);
      chk("t6_errcnt", 32'(oERR_CNT), (k + 2 > 255) ? 32'd255 : 32'(k + 2));
    end

    // iFVAL falls on the final pixel: clean end of frame
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("t6_last_conv_en", 32'(conv_en_s), 32'd1);
    chk("t6_last_dval", 32'(oDVAL), 32'd1);
    chk("t6_last_eof", 32'(oEOF), 32'd1);
    chk("t6_last_x", 32'(oX), 32'd7);
    chk("t6_last_y", 32'(oY), 32'd1);
    chk("t6_last_err", 32'(oERR), 32'd0);
    chk("t6_last_errcnt", 32'(oERR_CNT), 32'd255);
    cyc(1'b0, 1'b0);
    chk("t6_after_err", 32'(oERR), 32'd0);
    cyc(1'b1, 1'b1);
    chk("t6_next_sof", 32'(oSOF), 32'd1);
    chk("t6_next_phase", 32'(phase_s), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
